// File: rtl/arb_req_buffer_pkg.sv
// Shared defaults and sizing helpers for the arbitration request buffer.
package arb_req_buffer_pkg;

  localparam int unsigned NumReqsDflt  = 2;
  localparam int unsigned MsgNbitsDflt = 8;
  localparam int unsigned DepthDflt    = 2;

  // Count width: one extra bit so a full queue is distinguishable from empty.
  function automatic int unsigned cnt_nbits(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Pointer width: wraps naturally modulo a power-of-two depth.
  function automatic int unsigned ptr_nbits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Single-in/single-out FIFO holding one requester's pending messages.
module arb_req_fifo
  import arb_req_buffer_pkg::*;
#(
  parameter int unsigned p_msg_nbits = MsgNbitsDflt,
  parameter int unsigned p_depth     = DepthDflt
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             domain,
  input  logic                             enq_val,
  output logic                             enq_rdy,
  input  logic [p_msg_nbits-1:0]           enq_msg,
  input  logic                             deq_en,
  output logic [p_msg_nbits-1:0]           head_msg,
  output logic [cnt_nbits(p_depth)-1:0]    count
);

  localparam int unsigned PtrW = ptr_nbits(p_depth);
  localparam int unsigned CntW = cnt_nbits(p_depth);

  logic [p_msg_nbits-1:0] mem_q [p_depth];
  logic [p_msg_nbits-1:0] mem_d [p_depth];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   enq_fire_c;
  logic                   deq_fire_c;

  // Security label only matters to the type checker; no functional effect.
  logic unused_domain;
  assign unused_domain = domain;

  // Ready depends only on registered state; a full queue never accepts.
  assign enq_rdy    = (count_q != CntW'(p_depth));
  assign enq_fire_c = enq_val & enq_rdy;
  assign deq_fire_c = deq_en & (count_q != '0);
  assign head_msg   = mem_q[rd_ptr_q];
  assign count      = count_q;

  // Next-state: write at tail, advance pointers, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_fire_c) begin
      mem_d[wr_ptr_q] = enq_msg;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (deq_fire_c) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({enq_fire_c, deq_fire_c})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset flushes the queue immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < p_depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/arb_req_buffer.sv
// Requester side of the req/grant protocol: per-port queues, request gating,
// grant qualification and a one-hot output mux.
module arb_req_buffer
  import arb_req_buffer_pkg::*;
#(
  parameter int unsigned p_num_reqs  = NumReqsDflt,
  parameter int unsigned p_msg_nbits = MsgNbitsDflt,
  parameter int unsigned p_depth     = DepthDflt
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     domain,
  input  logic [p_num_reqs-1:0]                    in_val,
  output logic [p_num_reqs-1:0]                    in_rdy,
  input  logic [p_num_reqs*p_msg_nbits-1:0]        in_msg,
  output logic [p_num_reqs-1:0]                    reqs,
  input  logic [p_num_reqs-1:0]                    grants,
  output logic                                     out_val,
  output logic [p_msg_nbits-1:0]                   out_msg,
  input  logic                                     out_rdy,
  output logic [p_num_reqs*cnt_nbits(p_depth)-1:0] occupancy
);

  localparam int unsigned CntW = cnt_nbits(p_depth);

  logic [p_num_reqs-1:0]  nonempty_c;
  logic [p_num_reqs-1:0]  qual_c;
  logic [p_num_reqs-1:0]  sel_c;
  logic [p_msg_nbits-1:0] head_c [p_num_reqs];

  // One queue per requester.
  for (genvar i = 0; i < p_num_reqs; i++) begin : g_q
    logic [CntW-1:0] cnt;

    arb_req_fifo #(
      .p_msg_nbits (p_msg_nbits),
      .p_depth     (p_depth)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .domain   (domain),
      .enq_val  (in_val[i]),
      .enq_rdy  (in_rdy[i]),
      .enq_msg  (in_msg[i*p_msg_nbits +: p_msg_nbits]),
      .deq_en   (sel_c[i]),
      .head_msg (head_c[i]),
      .count    (cnt)
    );

    assign nonempty_c[i]              = (cnt != '0);
    assign occupancy[i*CntW +: CntW] = cnt;
  end

  // Request only when downstream can take it, so every grant is a transfer.
  assign reqs   = nonempty_c & {p_num_reqs{out_rdy}};
  // Drop grants on unrequested ports; lowest-index survivor wins.
  assign qual_c  = grants & reqs;
  assign sel_c   = qual_c & (~qual_c + p_num_reqs'(1));
  assign out_val = |qual_c;

  // AND-OR mux of queue heads; zero when nothing is selected.
  always_comb begin
    out_msg = '0;
    for (int unsigned i = 0; i < p_num_reqs; i++) begin
      if (sel_c[i]) begin
        out_msg = out_msg | head_c[i];
      end
    end
  end

  // Flag grant patterns the buffer has to ignore.
  always_ff @(posedge clk or negedge reset) begin
    if (reset) begin
      assert ((grants & ~reqs) == '0)
        else $warning("arb_req_buffer: grant on unrequested port ignored");
      assert ($onehot0(grants))
        else $warning("arb_req_buffer: multi-hot grant, lowest index used");
    end
  end

endmodule

// File: tb/tb_arb_req_buffer.sv
// Scoreboard bench for arb_req_buffer with a round-robin arbiter model.
module tb_arb_req_buffer;

  localparam int unsigned N     = 2;
  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 2;

  logic           clk;
  logic           rst_n;
  logic           domain;
  logic [N-1:0]   in_val;
  logic [N-1:0]   in_rdy;
  logic [N*W-1:0] in_msg;
  logic [N-1:0]   reqs;
  logic [N-1:0]   grants;
  logic           out_val;
  logic [W-1:0]   out_msg;
  logic           out_rdy;
  logic [3:0]     occupancy;

  logic           gnt_ovr;
  logic [N-1:0]   gnt_ovr_val;
  logic           rr_pri;

  logic [W-1:0]   sbq [N][$];
  logic [W-1:0]   out_log [$];

  int n_checks;
  int n_fail;

  arb_req_buffer #(
    .p_num_reqs  (N),
    .p_msg_nbits (W),
    .p_depth     (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .domain    (domain),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_msg    (in_msg),
    .reqs      (reqs),
    .grants    (grants),
    .out_val   (out_val),
    .out_msg   (out_msg),
    .out_rdy   (out_rdy),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin arbiter, combinational from reqs, with an override for illegal patterns.
  always_comb begin
    grants = '0;
    if (gnt_ovr) begin
      grants = gnt_ovr_val;
    end else if (!rr_pri) begin
      if (reqs[0])      grants = 2'b01;
      else if (reqs[1]) grants = 2'b10;
    end else begin
      if (reqs[1])      grants = 2'b10;
      else if (reqs[0]) grants = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rr_pri <= 1'b0;
    else if (out_val) rr_pri <= grants[0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: compare DUT against the scoreboard, then update it.
  task automatic cycle();
    logic [N-1:0] erdy, ereq, equal, esel;
    logic [W-1:0] emsg;
    logic [3:0]   eocc;
    @(negedge clk);
    emsg = '0;
    for (int i = 0; i < N; i++) begin
      erdy[i] = (sbq[i].size() < DEPTH);
      ereq[i] = (sbq[i].size() > 0) && out_rdy && rst_n;
    end
    equal = grants & ereq;
    esel  = equal & (~equal + 2'd1);
    for (int i = 0; i < N; i++) begin
      if (esel[i]) emsg = sbq[i][0];
    end
    eocc = {2'(sbq[1].size()), 2'(sbq[0].size())};
    chk("in_rdy", 32'(in_rdy), 32'(erdy));
    chk("reqs", 32'(reqs), 32'(ereq));
    chk("out_val", 32'(out_val), 32'(|equal));
    chk("out_msg", 32'(out_msg), 32'(emsg));
    chk("occupancy", 32'(occupancy), 32'(eocc));
    if (out_val) out_log.push_back(out_msg);
    for (int i = 0; i < N; i++) begin
      if (esel[i]) void'(sbq[i].pop_front());
    end
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (in_val[i] && erdy[i]) sbq[i].push_back(in_msg[i*W +: W]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic flush_model();
    for (int i = 0; i < N; i++) sbq[i].delete();
  endtask

  task automatic do_reset();
    in_val  = '0;
    out_rdy = 1'b0;
    gnt_ovr = 1'b0;
    rst_n   = 1'b0;
    flush_model();
    cycle();
    rst_n = 1'b1;
    cycle();
    out_log.delete();
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    domain      = 1'b0;
    in_val      = '0;
    in_msg      = '0;
    out_rdy     = 1'b1;
    gnt_ovr     = 1'b0;
    gnt_ovr_val = '0;
    rst_n       = 1'b0;

    // Reset held 3 cycles, then idle after release
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (2) cycle();

    // Single message, 1-cycle latency
    do_reset();
    out_rdy = 1'b1;
    in_val  = 2'b01;
    in_msg  = {8'h00, 8'hA5};
    cycle();
    in_val = '0;
    repeat (2) cycle();
    chk("t2_count", 32'(out_log.size()), 32'd1);
    if (out_log.size() > 0) chk("t2_msg", 32'(out_log[0]), 32'hA5);

    // Fill both queues while blocked, then drain round-robin
    do_reset();
    in_val = 2'b11;
    in_msg = {8'h21, 8'h11};
    cycle();
    in_msg = {8'h22, 8'h12};
    cycle();
    in_val = '0;
    cycle();
    out_rdy = 1'b1;
    repeat (4) cycle();
    cycle();
    chk("t3_count", 32'(out_log.size()), 32'd4);
    if (out_log.size() == 4) begin
      chk("t3_ord0", 32'(out_log[0]), 32'h11);
      chk("t3_ord1", 32'(out_log[1]), 32'h21);
      chk("t3_ord2", 32'(out_log[2]), 32'h12);
      chk("t3_ord3", 32'(out_log[3]), 32'h22);
    end

    // Full queue refuses input in the cycle it is dequeued
    do_reset();
    in_val = 2'b01;
    in_msg = {8'h00, 8'h31};
    cycle();
    in_msg = {8'h00, 8'h32};
    cycle();
    out_rdy = 1'b1;
    in_msg  = {8'h00, 8'h33};
    #1 chk("t4_full_rdy", 32'(in_rdy[0]), 32'd0);
    cycle();
    chk("t4_reopen_rdy", 32'(in_rdy[0]), 32'd1);
    cycle();
    in_val = '0;
    repeat (2) cycle();
    chk("t4_count", 32'(out_log.size()), 32'd3);
    if (out_log.size() == 3) chk("t4_last", 32'(out_log[2]), 32'h33);

    // Steady state: one in, one out every cycle through pointer wrap
    do_reset();
    out_rdy = 1'b1;
    in_val  = 2'b01;
    in_msg  = {8'h00, 8'h40};
    cycle();
    for (int k = 0; k < 8; k++) begin
      in_msg = {8'h00, 8'(8'h41 + k)};
      cycle();
      chk("t5_occ", 32'(occupancy), 32'd1);
    end
    in_val = '0;
    cycle();
    chk("t5_count", 32'(out_log.size()), 32'd9);
    if (out_log.size() == 9) chk("t5_last", 32'(out_log[8]), 32'h48);

    // Illegal grants: unrequested port, then multi-hot
    do_reset();
    out_rdy = 1'b1;
    in_val  = 2'b01;
    in_msg  = {8'h00, 8'h55};
    cycle();
    gnt_ovr     = 1'b1;
    gnt_ovr_val = 2'b10;
    in_val      = 2'b10;
    in_msg      = {8'h66, 8'h00};
    cycle();
    chk("t6_no_deq", 32'(occupancy), 32'h5);
    in_val      = '0;
    gnt_ovr_val = 2'b11;
    cycle();
    gnt_ovr = 1'b0;
    cycle();
    chk("t6_count", 32'(out_log.size()), 32'd2);
    if (out_log.size() == 2) begin
      chk("t6_first", 32'(out_log[0]), 32'h55);
      chk("t6_second", 32'(out_log[1]), 32'h66);
    end

    // Asynchronous reset flush with both queues full
    out_rdy = 1'b0;
    in_val  = 2'b11;
    in_msg  = {8'h71, 8'h61};
    cycle();
    in_msg  = {8'h72, 8'h62};
    cycle();
    in_val  = '0;
    chk("t6_full_occ", 32'(occupancy), 32'hA);
    rst_n = 1'b0;
    #1;
    chk("t6_async_occ", 32'(occupancy), 32'h0);
    chk("t6_async_rdy", 32'(in_rdy), 32'h3);
    chk("t6_async_val", 32'(out_val), 32'h0);
    flush_model();
    cycle();
    rst_n = 1'b1;
    repeat (2) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
